// File: rtl/sd_loader_pkg.sv
// Shared types and default constants for the SD instruction-sector loader.
package sd_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERROR
  } ld_state_e;

  localparam int unsigned INS_WORDS_DEF = 53;
  localparam int unsigned SECTOR_HW_DEF = 256;
  localparam int unsigned ADDR_W_DEF    = 11;
  localparam int unsigned TIMEOUT_DEF   = 1000000;

  // First halfword of each pair lands in bits [31:16].
  localparam bit HI_FIRST = 1'b1;

endpackage

// File: rtl/sd_hw_packer.sv
// Pairs consecutive 16-bit halfwords into 32-bit words; word_vld_o strobes
// combinationally on the second halfword of each pair.
module sd_hw_packer
  import sd_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        beat_i,
  input  logic [15:0] hw_i,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic        phase_q;
  logic [15:0] hi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else if (clear_i) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else if (beat_i) begin
      if (!phase_q) hi_q <= hw_i;
      phase_q <= ~phase_q;
    end
  end

  assign word_vld_o = beat_i & phase_q;
  assign word_o     = HI_FIRST ? {hi_q, hw_i} : {hw_i, hi_q};

endmodule

// File: rtl/sd_ins_loader.sv
// Loads one SD sector of halfwords into instruction memory, holding the CPU in
// reset until done. Optional LOADER_CHECKSUM_EN verifies an XOR checksum slot.
module sd_ins_loader
  import sd_loader_pkg::*;
#(
  parameter int unsigned INS_WORDS = INS_WORDS_DEF,
  parameter int unsigned SECTOR_HW = SECTOR_HW_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_error,
  output logic [8:0]        hw_cnt
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  ld_state_e         state_q, state_d;
  logic [8:0]        hw_cnt_q, hw_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              beat;
  logic              pk_vld;
  logic [31:0]       pk_word;
  logic [7:0]        widx;
  logic              is_write;
  logic              last_beat;
  logic              csum_ok;

  assign beat      = rd_valid && (state_q == LOAD) && !start;
  assign widx      = hw_cnt_q[8:1];
  assign is_write  = pk_vld && (32'(widx) < INS_WORDS);
  assign last_beat = beat && (hw_cnt_q == 9'(SECTOR_HW - 1));

  sd_hw_packer u_packer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (start),
    .beat_i     (beat),
    .hw_i       (rd_data),
    .word_vld_o (pk_vld),
    .word_o     (pk_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start)         csum_d = '0;
    else if (is_write) csum_d = csum_q ^ pk_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  // The last pair of the sector is the checksum slot; it is padding, so
  // csum_q is already final when it arrives.
  assign csum_ok = (csum_q == pk_word);
  assign csum    = csum_q;
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    hw_cnt_d = hw_cnt_q;
    timer_d  = timer_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (start) begin
      state_d  = LOAD;
      hw_cnt_d = '0;
      timer_d  = '0;
      addr_d   = '0;
    end else if (state_q == LOAD) begin
      if (rd_valid) begin
        timer_d  = '0;
        hw_cnt_d = hw_cnt_q + 9'd1;
        if (pk_vld) wdata_d = pk_word;
        if (is_write) begin
          we_d   = 1'b1;
          addr_d = ADDR_W'(32'(widx) << 2);
        end
        if (last_beat) state_d = csum_ok ? DONE : ERROR;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d = ERROR;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hw_cnt_q <= '0;
      timer_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      hw_cnt_q <= hw_cnt_d;
      timer_q  <= timer_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign hw_cnt     = hw_cnt_q;
  assign load_done  = (state_q == DONE);
  assign cpu_rst_n  = (state_q == DONE);
  assign load_error = (state_q == ERROR);

endmodule

// File: tb/tb_sd_ins_loader.sv
// Scoreboard bench for sd_ins_loader: expected writes are queued by the
// stimulus and popped by a monitor on each imem_we pulse.
module tb_sd_ins_loader;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic        imem_we;
  logic [10:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        load_done;
  logic        load_error;
  logic [8:0]  hw_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  sd_ins_loader #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .load_error (load_error),
    .hw_cnt     (hw_cnt)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum       (csum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_wr  = 0;
  logic [15:0] hw_arr[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && imem_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(mon_e.a));
        check("wr_data", 64'(imem_wdata), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic fill_pattern();
    for (int i = 0; i < 256; i++) hw_arr[i] = 16'(i + 1);
  endtask

  task automatic push_words(input int n);
    wr_t e;
    for (int w = 0; w < n && w < 53; w++) begin
      e.a = 11'(w * 4);
      e.d = {hw_arr[2*w], hw_arr[2*w+1]};
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      rd_valid = 1'b1;
      rd_data  = hw_arr[i];
      @(posedge clk); #1;
      rd_valid = 1'b0;
      repeat (gap - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic pulse_start(input logic with_valid);
    start    = 1'b1;
    rd_valid = with_valid;
    rd_data  = 16'hDEAD;
    @(posedge clk); #1;
    start    = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic full_sector(input int gap);
    int unsigned wr0;
    pulse_start(1'b0);
    @(negedge clk);
    check("armed_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    wr0 = n_wr;
    push_words(53);
    send_beats(256, gap);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("done_flags", {61'd0, load_done, cpu_rst_n, load_error}, {61'd0, 3'b110});
    check("done_hw_cnt", 64'(hw_cnt), 64'd256);
    check("write_count", 64'(n_wr - wr0), 64'd53);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic csum_test();
    logic [31:0] x;
    fill_pattern();
    x = '0;
    for (int w = 0; w < 53; w++) x = x ^ {hw_arr[2*w], hw_arr[2*w+1]};
    hw_arr[254] = x[31:16];
    hw_arr[255] = x[15:0];
    full_sector(1);
    check("csum_value", 64'(csum), 64'(x));
    hw_arr[255] = hw_arr[255] ^ 16'h0001;
    pulse_start(1'b0);
    push_words(53);
    send_beats(256, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("csum_bad_flags", {61'd0, load_done, cpu_rst_n, load_error}, {61'd0, 3'b001});
  endtask
`endif

  initial begin
    fill_pattern();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          {8'd0, imem_we, imem_addr, imem_wdata, cpu_rst_n, load_done, load_error, hw_cnt}, 64'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // rd_valid in IDLE is ignored
    send_beats(4, 1);
    @(negedge clk);
    check("idle_hw_cnt", 64'(hw_cnt), 64'd0);

    full_sector(3);
    full_sector(1);

    // stall timeout
    pulse_start(1'b0);
    push_words(5);
    send_beats(10, 1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("pre_timeout_err", 64'(load_error), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("timeout_flags", {61'd0, load_done, cpu_rst_n, load_error}, {61'd0, 3'b001});
    full_sector(3);

    // restart mid-load with a coincident beat
    pulse_start(1'b0);
    push_words(25);
    send_beats(51, 1);
    pulse_start(1'b1);
    @(negedge clk);
    check("restart_hw_cnt", 64'(hw_cnt), 64'd0);
    check("restart_sb_empty", 64'(exp_q.size()), 64'd0);
    full_sector(1);

    // reset mid-load
    pulse_start(1'b0);
    push_words(49);
    send_beats(100, 1);
    reset = 1'b0;
    #1;
    check("midload_reset",
          {8'd0, imem_we, imem_addr, imem_wdata, cpu_rst_n, load_done, load_error, hw_cnt}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    send_beats(10, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", {54'd0, cpu_rst_n, hw_cnt}, 64'd0);
    check("post_reset_sb", 64'(exp_q.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    csum_test();
`endif

    repeat (2) @(posedge clk);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_ins_loader.md
Name: sd_ins_loader

Overview:
Downstream of the SD-card data stage. Consumes the 16-bit halfword stream that stage delivers when it reads back the instruction sector. Packs halfword pairs into 32-bit instruction words and writes them into the CPU instruction memory. Holds the CPU in reset until the whole sector has been consumed, then releases it, or flags an error on stall.

Parameters:
INS_WORDS, 53, number of 32-bit instruction words to load (106 halfwords)
SECTOR_HW, 256, halfwords per SD sector; the loader consumes exactly this many per load
ADDR_W, 11, width of imem byte address
TIMEOUT, 1000000, max cycles between rd_valid beats while loading before error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: arm loader for a new sector read
rd_valid  in  1  one-cycle strobe: rd_data holds next halfword
rd_data  in  16  halfword from SD read path
imem_we  out  1  instruction memory write enable (one-cycle pulse)
imem_addr  out  ADDR_W  byte address of word being written (multiple of 4)
imem_wdata  out  32  packed instruction word
cpu_rst_n  out  1  active-low CPU reset; 0 until load completes
load_done  out  1  level: sector consumed successfully
load_error  out  1  level: stall timeout occurred
hw_cnt  out  9  halfwords consumed in current load

Behaviour:
- Reset (reset=0, async): state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, load_done=0, load_error=0, hw_cnt=0, internal hi-half reg=0, timeout counter=0.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE: wait for start. On start: clear hw_cnt, imem_addr, timer, load_done, load_error; cpu_rst_n=0; go LOAD. rd_valid ignored in IDLE.
- LOAD, per rd_valid beat: hw_cnt increments.
  - Even beat (hw_cnt[0]=0 before the increment): capture rd_data into the hi-half register.
  - Odd beat: imem_wdata={hi_half, rd_data}. First halfword of each pair is bits [31:16].
  - Odd beat with word index hw_cnt[8:1] < INS_WORDS: imem_we=1 for exactly the following cycle. imem_addr = word_index*4, truncated to ADDR_W.
  - Words at index >= INS_WORDS (padding): consumed and counted, never written.
- Write latency: imem_we asserts on the cycle after the second halfword's rd_valid. imem_addr and imem_wdata are stable that cycle.
- When beat number SECTOR_HW is consumed, go DONE on the next cycle. Any final write pulse still issues.
- Timeout: timer clears on every rd_valid and increments every LOAD cycle without one. When timer reaches TIMEOUT-1, go ERROR.
- DONE: load_done=1, cpu_rst_n=1, imem_we=0. Extra rd_valid beats ignored; hw_cnt holds at SECTOR_HW. start re-arms the loader (as from IDLE): cpu_rst_n drops to 0 in the same cycle the state changes to LOAD.
- ERROR: load_error=1, cpu_rst_n stays 0, no writes. Only start (retry) or reset exits.
- start while in LOAD: restart the load (counters cleared, same cycle as IDLE start); the partial pair is discarded.
- start and rd_valid in the same cycle: start wins; that beat is dropped.
- Reset mid-load: immediate return to reset values; CPU stays held.
- hw_cnt is 9 bits; SECTOR_HW ≤ 511 is required.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- With: a 32-bit XOR accumulator folds every written instruction word. The final word slot (index SECTOR_HW/2-1, within padding) is treated as the expected checksum. On completion, go DONE only if accumulator == that word, else ERROR. Extra output port csum out 32 exposes the accumulator.
- Without: no accumulator, no csum port; completion always goes DONE.

Decomposition:
- Package sd_loader_pkg: state enum (IDLE/LOAD/DONE/ERROR), default INS_WORDS, SECTOR_HW, TIMEOUT constants, halfword-order constant.
- One natural sub-module, sd_hw_packer: pairs halfwords into 32-bit words with a word-valid strobe. The FSM, timer and address logic stay in the top.

Test Plan:
- Reset, start, 256 beats of halfwords 0x0001..0x0100, one per 3 cycles → 53 imem_we pulses. First write addr 0, data 0x00010002. Last write addr 208 (0xD0), data 0x0069006A. Then load_done=1, cpu_rst_n=1, hw_cnt=256.
- 256 back-to-back rd_valid beats (every cycle) → identical write sequence; no beat dropped.
- Start, 10 beats, then silence with TIMEOUT=16 → ERROR after 16 idle cycles. load_error=1, cpu_rst_n=0. Start again plus a full sector → DONE.
- Start, 51 beats, then start pulse coincident with a rd_valid → that beat dropped, hw_cnt=0. The following full sector writes from addr 0 with fresh pairing.
- Reset asserted at beat 100 → all outputs return to reset values immediately. Subsequent rd_valid without start produces no writes.
- LOADER_CHECKSUM_EN: sector with slot-127 word equal to the XOR of words 0..52 → DONE. The same sector with one bit flipped in that word → ERROR.
